// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings, ALU operation codes and immediate decoding
// for the single-cycle core.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_type_t imm_type);
    case (imm_type)
      IMM_I:   gen_imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   gen_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   gen_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   gen_imm = {instr[31:12], 12'b0};
      IMM_J:   gen_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: gen_imm = 32'h0;
    endcase
  endfunction

  // Register-register and register-immediate forms share funct3; SUB only exists in the register form.
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt, input logic allow_sub);
    case (f3)
      F3_ADD:  alu_from_f3 = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_from_f3 = ALU_SLL;
      F3_SLT:  alu_from_f3 = ALU_SLT;
      F3_SLTU: alu_from_f3 = ALU_SLTU;
      F3_XOR:  alu_from_f3 = ALU_XOR;
      F3_SR:   alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_from_f3 = ALU_OR;
      F3_AND:  alu_from_f3 = ALU_AND;
      default: alu_from_f3 = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_alu.sv
// Combinational RV32I ALU with equality and signed/unsigned compare flags
// (a against b) used for branch resolution.
module rv32i_alu
  import rv32i_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alu_op,
  output logic [31:0] result,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  logic [4:0] shamt;

  assign shamt = b[4:0];
  assign eq    = (a == b);
  assign lt    = ($signed(a) < $signed(b));
  assign ltu   = (a < b);

  always_comb begin
    result = 32'h0;
    case (alu_op_t'(alu_op))
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_SLL:    result = a << shamt;
      ALU_SLT:    result = {31'b0, lt};
      ALU_SLTU:   result = {31'b0, ltu};
      ALU_XOR:    result = a ^ b;
      ALU_SRL:    result = a >> shamt;
      ALU_SRA:    result = $unsigned($signed(a) >>> shamt);
      ALU_OR:     result = a | b;
      ALU_AND:    result = a & b;
      ALU_PASS_B: result = b;
      default:    result = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core: fetch, decode, execute, memory access and
// writeback all complete within one enabled clock.
module rv32i_single_cycle_core
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clk_ce,
  output logic [XLEN-1:0] o_addr_i,
  input  logic [XLEN-1:0] i_data_in_i,
  output logic [XLEN-1:0] o_addr_d,
  input  logic [XLEN-1:0] i_data_rd_d,
  output logic [3:0]      o_wr_d,
  output logic            o_rd_d,
  output logic [XLEN-1:0] o_data_wr_d
);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] rf_reg [1:31];

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] rs1_val, rs2_val, imm;

  imm_type_t   imm_type;
  alu_op_t     alu_op;
  logic        a_is_pc, b_is_imm;
  logic        rd_we, is_load, is_store, is_branch, is_jal, is_jalr;

  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_eq, alu_lt, alu_ltu, branch_taken;
  logic [31:0] pc_plus4, pc_plus_imm, load_val, wb_val;
  logic [31:0] byte_word, half_word, store_data;
  logic [3:0]  store_strobe;

  assign instr  = i_data_in_i;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : rf_reg[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : rf_reg[rs2];
  assign imm     = gen_imm(instr, imm_type);

  always_comb begin
    imm_type  = IMM_I;
    alu_op    = ALU_ADD;
    a_is_pc   = 1'b0;
    b_is_imm  = 1'b1;
    rd_we     = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OP_LUI:    begin imm_type = IMM_U; alu_op = ALU_PASS_B; rd_we = 1'b1; end
      OP_AUIPC:  begin imm_type = IMM_U; a_is_pc = 1'b1; rd_we = 1'b1; end
      OP_JAL:    begin imm_type = IMM_J; is_jal = 1'b1; rd_we = 1'b1; end
      OP_JALR:   begin is_jalr = 1'b1; rd_we = 1'b1; end
      OP_BRANCH: begin imm_type = IMM_B; b_is_imm = 1'b0; is_branch = 1'b1; end
      OP_LOAD: begin
        if (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU) begin
          is_load = 1'b1;
          rd_we   = 1'b1;
        end
      end
      OP_STORE: begin
        imm_type = IMM_S;
        is_store = (f3 == F3_SB || f3 == F3_SH || f3 == F3_SW);
      end
      OP_IMM:    begin alu_op = alu_from_f3(f3, instr[30], 1'b0); rd_we = 1'b1; end
      OP_OP:     begin alu_op = alu_from_f3(f3, instr[30], 1'b1); b_is_imm = 1'b0; rd_we = 1'b1; end
      OP_FENCE, OP_SYSTEM: ;
      default: ;
    endcase
  end

  assign alu_a = a_is_pc ? pc_reg : rs1_val;
  assign alu_b = b_is_imm ? imm : rs2_val;

  rv32i_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .alu_op (alu_op),
    .result (alu_result),
    .eq     (alu_eq),
    .lt     (alu_lt),
    .ltu    (alu_ltu)
  );

  always_comb begin
    branch_taken = 1'b0;
    case (f3)
      F3_BEQ:  branch_taken = alu_eq;
      F3_BNE:  branch_taken = !alu_eq;
      F3_BLT:  branch_taken = alu_lt;
      F3_BGE:  branch_taken = !alu_lt;
      F3_BLTU: branch_taken = alu_ltu;
      F3_BGEU: branch_taken = !alu_ltu;
      default: branch_taken = 1'b0;
    endcase
  end

  assign pc_plus4    = pc_reg + 32'd4;
  assign pc_plus_imm = pc_reg + imm;

  always_comb begin
    pc_next = pc_plus4;
    if (is_jalr)
      pc_next = {alu_result[31:1], 1'b0};
    else if (is_jal || (is_branch && branch_taken))
      pc_next = pc_plus_imm;
  end

  // Memory returns the aligned word; shift the addressed lane down to bit 0.
  assign byte_word = i_data_rd_d >> {alu_result[1:0], 3'b000};
  assign half_word = i_data_rd_d >> {alu_result[1], 4'b0000};

  always_comb begin
    load_val = i_data_rd_d;
    case (f3)
      F3_LB:   load_val = {{24{byte_word[7]}}, byte_word[7:0]};
      F3_LH:   load_val = {{16{half_word[15]}}, half_word[15:0]};
      F3_LBU:  load_val = {24'b0, byte_word[7:0]};
      F3_LHU:  load_val = {16'b0, half_word[15:0]};
      default: load_val = i_data_rd_d;
    endcase
  end

  always_comb begin
    store_strobe = 4'b1111;
    store_data   = rs2_val;
    case (f3)
      F3_SB: begin
        store_strobe = 4'b0001 << alu_result[1:0];
        store_data   = {4{rs2_val[7:0]}};
      end
      F3_SH: begin
        store_strobe = 4'b0011 << {alu_result[1], 1'b0};
        store_data   = {2{rs2_val[15:0]}};
      end
      default: ;
    endcase
  end

  assign wb_val = is_load ? load_val : ((is_jal || is_jalr) ? pc_plus4 : alu_result);

  // Reset gates the data port combinationally so an in-flight store is dropped at once.
  assign o_addr_i    = pc_reg;
  assign o_rd_d      = i_rst && i_clk_ce && is_load;
  assign o_wr_d      = (i_rst && i_clk_ce && is_store) ? store_strobe : 4'b0000;
  assign o_addr_d    = (i_rst && (is_load || is_store)) ? alu_result : 32'h0;
  assign o_data_wr_d = (i_rst && is_store) ? store_data : 32'h0;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)
      pc_reg <= RESET_PC;
    else if (i_clk_ce)
      pc_reg <= pc_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_clk_ce && rd_we && (rd != 5'd0))
      rf_reg[rd] <= wb_val;
  end

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Directed program for the single-cycle RV32I core; the bench supplies each
// instruction for the expected PC and checks fetch and data-port outputs.
module tb_rv32i_single_cycle_core;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_clk_ce;
  logic [31:0] o_addr_i;
  logic [31:0] i_data_in_i;
  logic [31:0] o_addr_d;
  logic [31:0] i_data_rd_d;
  logic [3:0]  o_wr_d;
  logic        o_rd_d;
  logic [31:0] o_data_wr_d;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 i_clk = ~i_clk;

  rv32i_single_cycle_core dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clk_ce    (i_clk_ce),
    .o_addr_i    (o_addr_i),
    .i_data_in_i (i_data_in_i),
    .o_addr_d    (o_addr_d),
    .i_data_rd_d (i_data_rd_d),
    .o_wr_d      (o_wr_d),
    .o_rd_d      (o_rd_d),
    .o_data_wr_d (o_data_wr_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Present one instruction in the low clock phase and check the fetch address.
  task automatic run(input logic [31:0] instr, input logic [31:0] exp_pc, input logic ce);
    @(negedge i_clk);
    i_data_in_i = instr;
    i_clk_ce    = ce;
    #1;
    $display("step pc=%08h instr=%08h ce=%0b wr=%h rd=%0b addr_d=%08h data_wr=%08h",
             o_addr_i, instr, ce, o_wr_d, o_rd_d, o_addr_d, o_data_wr_d);
    chk("pc", o_addr_i, exp_pc);
  endtask

  initial begin
    i_rst       = 1'b0;
    i_clk_ce    = 1'b1;
    i_data_in_i = NOP;
    i_data_rd_d = 32'h0;

    // Reset: outputs idle even while a store is presented
    repeat (2) @(negedge i_clk);
    i_data_in_i = 32'h1030_2023;
    #1;
    chk("rst_pc", o_addr_i, 32'h0);
    chk("rst_wr", {28'b0, o_wr_d}, 32'h0);
    chk("rst_rd", {31'b0, o_rd_d}, 32'h0);
    chk("rst_addr_d", o_addr_d, 32'h0);
    chk("rst_data_wr", o_data_wr_d, 32'h0);

    @(negedge i_clk);
    i_rst       = 1'b1;
    i_data_in_i = NOP;
    #1;
    chk("first_pc", o_addr_i, 32'h0);
    chk("nop_wr", {28'b0, o_wr_d}, 32'h0);
    chk("nop_rd", {31'b0, o_rd_d}, 32'h0);
    run(NOP, 32'h4, 1'b1);
    run(NOP, 32'h8, 1'b1);
    chk("nop_addr_d", o_addr_d, 32'h0);

    // ADDI/ADD then SW x3,0x100(x0)
    run(32'h0050_0093, 32'h0C, 1'b1);
    run(32'hFFD0_0113, 32'h10, 1'b1);
    run(32'h0020_81B3, 32'h14, 1'b1);
    run(32'h1030_2023, 32'h18, 1'b1);
    chk("sw_wr", {28'b0, o_wr_d}, 32'hF);
    chk("sw_addr", o_addr_d, 32'h100);
    chk("sw_data", o_data_wr_d, 32'h0000_0002);
    chk("sw_rd", {31'b0, o_rd_d}, 32'h0);

    // x1 = 0x123456AB, SB x1,0x103(x0)
    run(32'h1234_50B7, 32'h1C, 1'b1);
    run(32'h6AB0_8093, 32'h20, 1'b1);
    run(32'h1010_01A3, 32'h24, 1'b1);
    chk("sb_wr", {28'b0, o_wr_d}, 32'h8);
    chk("sb_data", o_data_wr_d, 32'hABAB_ABAB);
    chk("sb_addr", o_addr_d, 32'h103);

    // LB x4,0x103(x0) from word 0xAB000000, observe through SW x4
    i_data_rd_d = 32'hAB00_0000;
    run(32'h1030_0203, 32'h28, 1'b1);
    chk("lb_rd", {31'b0, o_rd_d}, 32'h1);
    chk("lb_wr", {28'b0, o_wr_d}, 32'h0);
    chk("lb_addr", o_addr_d, 32'h103);
    run(32'h0040_2023, 32'h2C, 1'b1);
    chk("lb_val", o_data_wr_d, 32'hFFFF_FFAB);
    run(32'h1030_4283, 32'h30, 1'b1);
    chk("lbu_rd", {31'b0, o_rd_d}, 32'h1);
    run(32'h0050_2023, 32'h34, 1'b1);
    chk("lbu_val", o_data_wr_d, 32'h0000_00AB);

    // BNE countdown from 3: body at 0x3C runs three times
    run(32'h0030_0093, 32'h38, 1'b1);
    for (int i = 0; i < 3; i++) begin
      run(32'hFFF0_8093, 32'h3C, 1'b1);
      run(32'hFE00_9EE3, 32'h40, 1'b1);
    end
    // JALR x0,0x20(x0), then JAL x1,+0x10 at 0x20
    run(32'h0200_0067, 32'h44, 1'b1);
    run(32'h0100_00EF, 32'h20, 1'b1);
    run(32'h0010_2023, 32'h30, 1'b1);
    chk("jal_link", o_data_wr_d, 32'h0000_0024);

    // LUI x5,0x10, then clock enable low for 5 cycles
    run(32'h0001_02B7, 32'h34, 1'b1);
    for (int i = 0; i < 3; i++)
      run(32'h0012_8293, 32'h38, 1'b0);
    run(32'h0050_2023, 32'h38, 1'b0);
    chk("hold_wr", {28'b0, o_wr_d}, 32'h0);
    run(32'h0000_2303, 32'h38, 1'b0);
    chk("hold_rd", {31'b0, o_rd_d}, 32'h0);
    run(32'h0012_8293, 32'h38, 1'b1);
    run(32'h0050_2023, 32'h3C, 1'b1);
    chk("resume_wr", {28'b0, o_wr_d}, 32'hF);
    chk("resume_x5", o_data_wr_d, 32'h0001_0001);

    // JALR x0,0(x5) clears bit 0 of the target
    run(32'h0002_8067, 32'h40, 1'b1);
    run(32'h0050_2023, 32'h0001_0000, 1'b1);
    chk("end_wr", {28'b0, o_wr_d}, 32'hF);

    // Reset asserted in the middle of that store
    i_rst = 1'b0;
    #1;
    chk("midrst_wr", {28'b0, o_wr_d}, 32'h0);
    chk("midrst_data", o_data_wr_d, 32'h0);
    chk("midrst_pc", o_addr_i, 32'h0);
    @(negedge i_clk);
    i_rst       = 1'b1;
    i_data_in_i = NOP;
    #1;
    chk("restart_pc", o_addr_i, 32'h0);
    run(NOP, 32'h4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
